// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   One valid/ready stream channel carrying a control bundle plus NWORDS
//   32-bit payload words. The producer side uses the master modport and the
//   consumer side uses the slave modport.
//   valid : entry is present this cycle (driven by master)
//   ready : consumer accepts this cycle (driven by slave)
//   ctrl  : control bundle, CTRL_W bits (driven by master)
//   data  : payload, word k at [32k+31:32k] (driven by master)
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 3,
  parameter int NWORDS = 3
);
  logic                   valid;
  logic                   ready;
  logic [CTRL_W-1:0]      ctrl;
  logic [32*NWORDS-1:0]   data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register with valid/ready handshake,
//   synchronous flush and an optional 2-entry skid buffer. Empty or flushed
//   slots present all-zero control and data so a bubble never causes a
//   write-back side effect downstream. A saturating counter records the
//   number of cycles the output was empty (CPI debug).
// Parameters
//   CTRL_W : control bundle width (>=1)
//   NWORDS : number of 32-bit payload words (>=1)
//   SKID   : 1 = 2-entry skid buffer, registered up.ready
//            0 = single entry, up.ready combinational from dn.ready
//   CNT_W  : bubble counter width
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous kill of all held entries
//   up         : upstream channel (slave), up.ready is the stage's in_ready
//   dn         : downstream channel (master), dn.ready = 0 stalls the stage
//   bubble_cnt : cycles with dn.valid = 0 since reset, saturating
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int NWORDS = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     dn,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam int DATA_W = 32 * NWORDS;

  // Occupancy encoding {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic                 main_valid_r;
  logic [CTRL_W-1:0]    main_ctrl_r;
  logic [DATA_W-1:0]    main_data_r;
  logic                 skid_valid_r;
  logic [CTRL_W-1:0]    skid_ctrl_r;
  logic [DATA_W-1:0]    skid_data_r;

  logic                 main_valid_s;
  logic [CTRL_W-1:0]    main_ctrl_s;
  logic [DATA_W-1:0]    main_data_s;
  logic                 skid_valid_s;
  logic [CTRL_W-1:0]    skid_ctrl_s;
  logic [DATA_W-1:0]    skid_data_s;

  logic                 in_ready_s;
  logic                 xfer_in_s;
  logic                 xfer_out_s;
  logic [1:0]           state_s;

  // With a skid buffer the upstream ready is a pure register output, so no
  // combinational path runs from dn.ready back to up.ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready_s = ~skid_valid_r;
    end else begin : g_comb_ready
      assign in_ready_s = ~main_valid_r | dn.ready;
    end
  endgenerate

  assign up.ready   = in_ready_s;
  assign xfer_in_s  = up.valid & in_ready_s;
  assign xfer_out_s = main_valid_r & dn.ready;
  assign state_s    = {skid_valid_r, main_valid_r};

  // Outputs come straight from the main entry, which is kept zeroed when empty.
  assign dn.valid = main_valid_r;
  assign dn.ctrl  = main_ctrl_r;
  assign dn.data  = main_data_r;

  // Next-state of the main and skid entries.
  always_comb begin
    main_valid_s = main_valid_r;
    main_ctrl_s  = main_ctrl_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_data_s  = skid_data_r;

    if (flush) begin
      // Flush wins over everything; an entry offered this cycle is dropped.
      main_valid_s = 1'b0;
      main_ctrl_s  = {CTRL_W{1'b0}};
      main_data_s  = {DATA_W{1'b0}};
      skid_valid_s = 1'b0;
      skid_ctrl_s  = {CTRL_W{1'b0}};
      skid_data_s  = {DATA_W{1'b0}};
    end else begin
      case (state_s)
        ST_EMPTY: begin
          if (xfer_in_s) begin
            main_valid_s = 1'b1;
            main_ctrl_s  = up.ctrl;
            main_data_s  = up.data;
          end else begin
            main_valid_s = 1'b0;
          end
        end
        ST_FULL: begin
          if (xfer_in_s && xfer_out_s) begin
            main_ctrl_s  = up.ctrl;
            main_data_s  = up.data;
          end else if (xfer_out_s) begin
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
            main_data_s  = {DATA_W{1'b0}};
          end else if (xfer_in_s && (SKID != 0)) begin
            // Downstream stalled while upstream delivered: park in the skid.
            skid_valid_s = 1'b1;
            skid_ctrl_s  = up.ctrl;
            skid_data_s  = up.data;
          end else begin
            main_valid_s = 1'b1;
          end
        end
        ST_SKID: begin
          if (xfer_out_s) begin
            main_ctrl_s  = skid_ctrl_r;
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
            skid_ctrl_s  = {CTRL_W{1'b0}};
            skid_data_s  = {DATA_W{1'b0}};
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty.
          main_valid_s = 1'b0;
          main_ctrl_s  = {CTRL_W{1'b0}};
          main_data_s  = {DATA_W{1'b0}};
          skid_valid_s = 1'b0;
          skid_ctrl_s  = {CTRL_W{1'b0}};
          skid_data_s  = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // Entry registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_ctrl_r  <= main_ctrl_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_data_r  <= skid_data_s;
    end
  end

  // Saturating count of cycles presenting a bubble downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (!main_valid_r && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule
